// File: rtl/unary_stream_tx.sv
// Binary-to-unary operand transmitter: streams thermometer-coded A/B frames, then holds the write phase.
// Optional macro UNARY_TX_SAT_EN clamps over-range operands; without it they are rejected with an err pulse.
module unary_stream_tx #(
    parameter int W            = 5,
    parameter int LEN          = 19,
    parameter int WRITE_CYCLES = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_val,
    input  logic [W-1:0] b_val,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int MAXC = (LEN > WRITE_CYCLES) ? LEN : WRITE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int XW   = (CW > W) ? CW : W;

    localparam logic [W-1:0]  LEN_V       = W'(LEN);
    localparam logic [CW-1:0] STREAM_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] WRITE_LAST  = CW'(WRITE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          stream_a_q, stream_a_d;
    logic          stream_b_q, stream_b_d;
    logic          en_q, en_d;
    logic          rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef UNARY_TX_SAT_EN
`else
    logic          err_q, err_d;
`endif

    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through this block can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
`ifdef UNARY_TX_SAT_EN
`else
        err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef UNARY_TX_SAT_EN
                    a_d     = (a_val > LEN_V) ? LEN_V : a_val;
                    b_d     = (b_val > LEN_V) ? LEN_V : b_val;
                    state_d = STREAM;
                    cnt_d   = '0;
`else
                    // Over-range pairs are consumed but never started.
                    if ((a_val > LEN_V) || (b_val > LEN_V)) begin
                        err_d = 1'b1;
                    end else begin
                        a_d     = a_val;
                        b_d     = b_val;
                        state_d = STREAM;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from the next state so they line up with it once registered.
        stream_a_d = (state_d == STREAM) && (XW'(cnt_d) < XW'(a_d));
        stream_b_d = (state_d == STREAM) && (XW'(cnt_d) < XW'(b_d));
        en_d       = (state_d != IDLE);
        rw_d       = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every register samples the pre-edge values.
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            stream_a_q <= 1'b0;
            stream_b_q <= 1'b0;
            en_q       <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UNARY_TX_SAT_EN
`else
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            stream_a_q <= stream_a_d;
            stream_b_q <= stream_b_d;
            en_q       <= en_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UNARY_TX_SAT_EN
`else
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign A             = stream_a_q;
    assign B             = stream_b_q;
    assign en            = en_q;
    assign read_or_write = rw_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef UNARY_TX_SAT_EN
    assign err           = 1'b0;
`else
    assign err           = err_q;
`endif

endmodule

// File: tb/tb_unary_stream_tx.sv
// Self-checking bench for unary_stream_tx: table of directed operand pairs, reset corner cases,
// and random pairs checked cycle by cycle against a frame model built from index arithmetic.
module tb_unary_stream_tx;
    localparam int W     = 5;
    localparam int LEN   = 19;
    localparam int WC    = 20;
    localparam int FRAME = LEN + WC + 1;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a_val    = '0;
    logic [W-1:0] b_val    = '0;
    logic         in_ready, A, B, en, read_or_write, busy, done, err;
    logic [7:0]   obs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unary_stream_tx #(.W(W), .LEN(LEN), .WRITE_CYCLES(WC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_val        (a_val),
        .b_val        (b_val),
        .A            (A),
        .B            (B),
        .en           (en),
        .read_or_write(read_or_write),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    assign obs = {in_ready, A, B, en, read_or_write, busy, done, err};

    typedef struct {
        int a;
        int b;
        int exp_a;
        int exp_b;
        bit exp_rej;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b want %b (in_ready,A,B,en,rw,busy,done,err)", name, act, expv);
        end
    endtask

    // Expected outputs i cycles after the handshake edge, from the frame rules alone.
    function automatic logic [7:0] exp_vec(input int i, input int ea, input int eb, input bit rej);
        logic [7:0] v;
        v = 8'b1000_0000;
        if (rej)
            v[0] = (i == 1);
        else if (i <= LEN)
            v = {1'b0, (i - 1 < ea), (i - 1 < eb), 1'b1, 1'b0, 1'b1, 2'b00};
        else if (i <= LEN + WC)
            v = 8'b0001_1100;
        else
            v = 8'b1000_0010;
        return v;
    endfunction

    function automatic void model(input int a, input int b, output int ea, output int eb, output bit rej);
`ifdef UNARY_TX_SAT_EN
        ea  = (a > LEN) ? LEN : a;
        eb  = (b > LEN) ? LEN : b;
        rej = 1'b0;
`else
        ea  = a;
        eb  = b;
        rej = (a > LEN) || (b > LEN);
`endif
    endfunction

    // Called mid-cycle; the handshake happens on the next rising edge.
    task automatic start_txn(input int a, input int b);
        a_val    = W'(a);
        b_val    = W'(b);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_val    = W'($urandom);
        b_val    = W'($urandom);
    endtask

    task automatic check_frame(input int ea, input int eb, input bit rej, input string tag);
        int n;
        n = rej ? 3 : FRAME;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, i), obs, exp_vec(i, ea, eb, rej));
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle%0d", tag, i), obs, 8'b1000_0000);
        end
    endtask

    vec_t tbl[7];

    initial begin
        int ea, eb, a, b, gap;
        bit rej;

        tbl[0] = '{a: 19, b: 3,  exp_a: 19, exp_b: 3,  exp_rej: 1'b0};
        tbl[1] = '{a: 0,  b: 0,  exp_a: 0,  exp_b: 0,  exp_rej: 1'b0};
        tbl[2] = '{a: 5,  b: 7,  exp_a: 5,  exp_b: 7,  exp_rej: 1'b0};
        tbl[3] = '{a: 1,  b: 18, exp_a: 1,  exp_b: 18, exp_rej: 1'b0};
`ifdef UNARY_TX_SAT_EN
        tbl[4] = '{a: 25, b: 2,  exp_a: 19, exp_b: 2,  exp_rej: 1'b0};
        tbl[5] = '{a: 20, b: 20, exp_a: 19, exp_b: 19, exp_rej: 1'b0};
        tbl[6] = '{a: 0,  b: 31, exp_a: 0,  exp_b: 19, exp_rej: 1'b0};
`else
        tbl[4] = '{a: 25, b: 2,  exp_a: 0,  exp_b: 0,  exp_rej: 1'b1};
        tbl[5] = '{a: 20, b: 20, exp_a: 0,  exp_b: 0,  exp_rej: 1'b1};
        tbl[6] = '{a: 0,  b: 31, exp_a: 0,  exp_b: 0,  exp_rej: 1'b1};
`endif

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check("reset async", obs, 8'b1000_0000);
        @(negedge clk);
        check("reset held", obs, 8'b1000_0000);
        rst_n = 1'b1;
        idle_check(10, "post-reset");

        // Directed table, each request issued in the done cycle of the previous one.
        for (int t = 0; t < 7; t++) begin
            start_txn(tbl[t].a, tbl[t].b);
            check_frame(tbl[t].exp_a, tbl[t].exp_b, tbl[t].exp_rej,
                        $sformatf("tbl%0d(%0d,%0d)", t, tbl[t].a, tbl[t].b));
        end

        // Reset in the middle of a stream at k=8.
        idle_check(2, "pre-midreset");
        start_txn(12, 12);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("midrst cyc%0d", i), obs, exp_vec(i, 12, 12, 1'b0));
        end
        #1 rst_n = 1'b0;
        #1 check("midrst async", obs, 8'b1000_0000);
        @(negedge clk);
        check("midrst held", obs, 8'b1000_0000);
        rst_n = 1'b1;
        idle_check(2, "post-midreset");
        start_txn(4, 4);
        check_frame(4, 4, 1'b0, "after-midrst(4,4)");

        // Random pairs with random idle gaps (gap 0 is back-to-back).
        for (int r = 0; r < 30; r++) begin
            gap = $urandom_range(0, 2);
            idle_check(gap, $sformatf("rnd%0d", r));
            a = $urandom_range(0, 23);
            b = $urandom_range(0, 23);
            model(a, b, ea, eb, rej);
            start_txn(a, b);
            check_frame(ea, eb, rej, $sformatf("rnd%0d(%0d,%0d)", r, a, b));
        end

        idle_check(3, "final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unary_stream_tx.md
# unary_stream_tx

Binary-to-unary stream transmitter that drives the operand side of the unary adder. It accepts a pair of binary operands over a valid/ready handshake and serialises each as a thermometer-coded bitstream on `A` and `B`: `val` ones, then zeros, for a fixed frame length. After the frame it sequences the `en` and `read_or_write` controls so the downstream adder switches to its output (write) phase, then signals completion.

## Interface
Parameters:
- `W`, 5: operand width in bits.
- `LEN`, 19: stream frame length in cycles. Constraint: `LEN` ≤ 2^W − 1.
- `WRITE_CYCLES`, 20: number of cycles the write phase is held. Must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `a_val` in W: operand A, binary.
- `b_val` in W: operand B, binary.
- `A` out 1: unary stream for operand A.
- `B` out 1: unary stream for operand B.
- `en` out 1: downstream enable.
- `read_or_write` out 1: 0 = read (stream) phase, 1 = write (output) phase.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `err` out 1: one-cycle pulse flagging an over-range operand (only when `UNARY_TX_SAT_EN` is undefined).

## Operation
- FSM states: IDLE, STREAM, WRITE.
- IDLE:
  - `in_ready`=1.
  - Handshake = `in_valid && in_ready` sampled on a rising edge.
  - On handshake, latch `a_val`/`b_val`, clear the cycle counter, and go to STREAM.
- STREAM:
  - Lasts exactly `LEN` cycles, k = 0..LEN−1.
  - `A` = (k < a_lat), `B` = (k < b_lat).
  - `en`=1, `read_or_write`=0.
  - After cycle k=LEN−1, go to WRITE.
- WRITE:
  - Lasts exactly `WRITE_CYCLES` cycles.
  - `A`=`B`=0, `en`=1, `read_or_write`=1.
  - After the last cycle, return to IDLE and pulse `done`.
- `busy`=1 in STREAM and WRITE; `in_ready`=0 there.
- The counter is ceil(log2(max(LEN, WRITE_CYCLES)+1)) bits wide. It never wraps within a state and is cleared on every state entry.
- Comparisons are unsigned. A latched value of 0 gives an all-zero stream; a latched value equal to `LEN` gives an all-one stream.
- Operands are latched only at the handshake. Input changes during a transaction are ignored.
- Reset (`rst_n`=0, at any time including mid-stream): go to IDLE immediately. Reset values:
  - `A`, `B`, `en`, `read_or_write`, `busy`, `done`, `err` = 0.
  - `in_ready` = 1.
  - Latched operands and counter = 0.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is decoded directly from state==IDLE.
- Handshake at edge T0: stream bit k=0 appears on `A`/`B`, with `en`=1, in the cycle after T0 (latency 1).
- Sequence length: `en` is high for exactly LEN + WRITE_CYCLES consecutive cycles. `read_or_write` rises on the first WRITE cycle, with no gap after the last STREAM cycle.
- `done`, `in_ready` and `busy`=0 are all asserted in the cycle after the last WRITE cycle. In that same cycle `en`=0 and `read_or_write`=0.
- Back-to-back: a handshake in the `done` cycle is accepted. The next STREAM starts in the following cycle, so `en` drops for exactly 1 cycle between transactions.
- `in_valid` is held low in IDLE: outputs are stable, and `done`/`err` are not re-asserted.

## Configuration
- Macro: `UNARY_TX_SAT_EN`.
- Defined (saturation compiled in):
  - An operand greater than `LEN` is clamped to `LEN` at latch time.
  - The transaction proceeds normally.
  - `err` is tied to 0.
- Undefined (saturation compiled out):
  - A handshake with `a_val` > `LEN` or `b_val` > `LEN` is consumed but rejected.
  - `err` pulses for 1 cycle after the handshake.
  - The FSM stays in IDLE: no `en`, no stream, no `done`.
  - Operands within range behave identically in both builds.

## Test plan
- Reset with defaults, `in_valid`=0 → all outputs 0 except `in_ready`=1. Release reset and wait 10 cycles → outputs unchanged.
- `a_val`=19, `b_val`=3 → `A`=1 for 19 cycles. `B`=1 for 3 cycles, then 0 for 16 cycles. `en`=1 for 39 cycles; `read_or_write`=1 on the last 20 of them. `done` pulses once, 40 cycles after the handshake.
- `a_val`=0, `b_val`=0, then an immediate second request `a_val`=5, `b_val`=7 presented in the `done` cycle → first frame is all zeros. Second frame starts with exactly 1 idle `en`=0 cycle between frames; `A` has 5 ones and `B` has 7 ones.
- Assert `rst_n`=0 at stream cycle k=8 of a (12, 12) transaction → all outputs 0 asynchronously and `in_ready`=1. A new (4, 4) request after release streams exactly 4 ones on each of `A` and `B`.
- `a_val`=25, `b_val`=2:
  - With `UNARY_TX_SAT_EN` → `A`=1 for all 19 cycles, `B` has 2 ones, `err`=0.
  - Without it → `err` pulses 1 cycle, `en` stays 0, `done` is never asserted, and `in_ready` stays 1.
